inst_bus_if: RTL and testbench

Instruction-side bus interface that sits directly upstream of the CPU core's fetch port. It converts the core's simple `rom_ce`/`rom_addr`/`rom_data` fetch request into single-beat, read-only Wishbone-style cycles toward instruction memory. It raises a stall request while a fetch is outstanding, holds fetched data while the pipeline is stalled, and aborts hung transfers with a timeout.

---
 rtl/inst_bus_pkg.sv | 13 +
 rtl/bus_timeout_cnt.sv | 30 +++
 rtl/inst_bus_if.sv | 97 +++++++++
 tb/tb_inst_bus_if.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_bus_pkg.sv
// Shared types and constants for the instruction-side Wishbone fetch interface.
package inst_bus_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } bus_state_e;

  localparam logic [31:0] NOP_INST   = 32'h0;
  localparam logic [3:0]  WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts BUSY cycles without ack; expire flags the last allowed cycle.
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_ctl;
    assign unused_ctl = clk ^ rst ^ clear ^ en;
    assign expire     = 1'b0;
  end else begin : g_on
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       cnt <= '0;
      else if (clear) cnt <= '0;
      else if (en)    cnt <= cnt + CW'(1);
    end

    // Expire in the cycle that would be the TIMEOUT_CYCLES-th wait.
    assign expire = (cnt == CW'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/inst_bus_if.sv
// Converts the core's rom_ce/rom_addr fetch into single-beat read-only
// Wishbone cycles, with stall request, stall-hold of fetched data and timeout.
module inst_bus_if
  import inst_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_data_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        err_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o
);

  bus_state_e  state, state_nxt;
  logic [31:0] hold;
  logic        expire;
  logic        launch, kill, take, abort, cnt_en;

  assign launch = (state == IDLE) & cpu_ce_i & ~flush_i;
  // Flush or a withdrawn fetch enable cancels the transfer, beating ack and timeout.
  assign kill   = flush_i | ~cpu_ce_i;
  assign take   = (state == BUSY) & ~kill & wb_ack_i;
  assign abort  = (state == BUSY) & ~kill & ~wb_ack_i & expire;
  assign cnt_en = (state == BUSY) & ~wb_ack_i;

  bus_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (launch),
    .en     (cnt_en),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (launch) state_nxt = BUSY;
      BUSY: begin
        if (kill || abort) state_nxt = IDLE;
        else if (wb_ack_i) state_nxt = stall_i ? WAIT_STALL : IDLE;
      end
      WAIT_STALL: if (!stall_i || flush_i) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_data_o = NOP_INST;
    stallreq_o = 1'b0;
    case (state)
      IDLE:       stallreq_o = rst & cpu_ce_i & ~flush_i;
      BUSY: begin
        if (take)                cpu_data_o = wb_dat_i;
        else if (!kill && !abort) stallreq_o = 1'b1;
      end
      WAIT_STALL: cpu_data_o = hold;
      default:    cpu_data_o = NOP_INST;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_adr_o <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      hold     <= '0;
      err_o    <= 1'b0;
    end else begin
      wb_cyc_o <= (state_nxt == BUSY);
      wb_stb_o <= (state_nxt == BUSY);
      err_o    <= abort;
      if (launch) wb_adr_o <= cpu_addr_i;
      if (take)   hold     <= wb_dat_i;
    end
  end

  assign wb_we_o  = 1'b0;
  assign wb_sel_o = WB_SEL_ALL;

endmodule

// File: tb/tb_inst_bus_if.sv
// Directed bench for inst_bus_if: transaction-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_inst_bus_if;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_o;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stallreq_o, err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;

  always #5 clk = ~clk;

  inst_bus_if #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_o(cpu_data_o), .stall_i(stall_i), .flush_i(flush_i),
    .stallreq_o(stallreq_o), .err_o(err_o), .wb_adr_o(wb_adr_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Slave: acks after sl_wait cycles of cyc, never if sl_never, stray ack if sl_stray.
  int          sl_wait = 0;
  int          sl_cnt = 0;
  bit          sl_never = 1'b0;
  bit          sl_stray = 1'b0;
  logic [31:0] sl_data = '0;
  assign wb_dat_i = sl_data;

  initial forever begin
    @(posedge clk); #2;
    if (!wb_cyc_o) begin
      sl_cnt   = 0;
      wb_ack_i = sl_stray;
    end else begin
      wb_ack_i = !sl_never && (sl_cnt == sl_wait);
      sl_cnt++;
    end
  end

  // Transaction-level model: outstanding fetch, BUSY cycles elapsed, held word.
  bit          m_busy = 1'b0, m_held = 1'b0, m_err = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_adr = '0, m_hold = '0;

  always @(negedge clk) begin : model
    logic [31:0] e_data;
    logic        e_stall;
    bit          nerr;
    if (!rst) begin
      m_busy = 0; m_held = 0; m_err = 0; m_cnt = 0; m_adr = '0; m_hold = '0;
    end
    e_data  = '0;
    e_stall = 1'b0;
    if (rst) begin
      if (m_busy) begin
        if (flush_i || !cpu_ce_i) ;
        else if (wb_ack_i)         e_data  = wb_dat_i;
        else if (m_cnt + 1 != TO)  e_stall = 1'b1;
      end else if (m_held) e_data = m_hold;
      else e_stall = cpu_ce_i && !flush_i;
    end
    chk("m_cyc",   wb_cyc_o,   m_busy);
    chk("m_stb",   wb_stb_o,   m_busy);
    chk("m_adr",   wb_adr_o,   m_adr);
    chk("m_err",   err_o,      m_err);
    chk("m_we",    wb_we_o,    1'b0);
    chk("m_sel",   wb_sel_o,   4'hF);
    chk("m_data",  cpu_data_o, e_data);
    chk("m_stall", stallreq_o, e_stall);
    if (rst) begin
      nerr = 0;
      if (m_busy) begin
        if (flush_i || !cpu_ce_i) m_busy = 0;
        else if (wb_ack_i) begin m_busy = 0; m_hold = wb_dat_i; m_held = stall_i; end
        else if (m_cnt + 1 == TO) begin m_busy = 0; nerr = 1; end
        else m_cnt++;
      end else if (m_held) begin
        if (!stall_i || flush_i) m_held = 0;
      end else if (cpu_ce_i && !flush_i) begin
        m_busy = 1; m_adr = cpu_addr_i; m_cnt = 0;
      end
      m_err = nerr;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_data", cpu_data_o, 32'h0);
    chk("rst_stall", stallreq_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    tick(); rst = 1'b1;
    tick();

    // Zero-wait fetch at 0x0
    sl_data = 32'h3C01_0101; sl_wait = 0; sl_never = 0;
    cpu_ce_i = 1; cpu_addr_i = 32'h0;
    @(negedge clk);
    chk("zw_req_stall", stallreq_o, 1'b1);
    chk("zw_req_cyc", wb_cyc_o, 1'b0);
    tick(); @(negedge clk);
    chk("zw_ack_data", cpu_data_o, 32'h3C01_0101);
    chk("zw_ack_stall", stallreq_o, 1'b0);
    chk("zw_ack_cyc", wb_cyc_o, 1'b1);
    chk("zw_ack_adr", wb_adr_o, 32'h0);
    tick(); cpu_ce_i = 0;
    tick();

    // 3-wait slave, address changes mid-transfer
    sl_data = 32'hAABB_0011; sl_wait = 3;
    cpu_ce_i = 1; cpu_addr_i = 32'h40;
    for (int i = 1; i <= 4; i++) begin
      tick(); cpu_addr_i = 32'h1000 + i;
      @(negedge clk);
      chk("w3_cyc", wb_cyc_o, 1'b1);
      chk("w3_stall", stallreq_o, (i < 4));
      chk("w3_adr", wb_adr_o, 32'h40);
    end
    chk("w3_data", cpu_data_o, 32'hAABB_0011);
    tick(); cpu_ce_i = 0;
    @(negedge clk);
    chk("w3_end_cyc", wb_cyc_o, 1'b0);
    tick();

    // Ack under stall: word held in WAIT_STALL
    sl_data = 32'h1234_5678; sl_wait = 0;
    cpu_ce_i = 1; cpu_addr_i = 32'h100; stall_i = 1;
    tick(); @(negedge clk);
    chk("st_ack_data", cpu_data_o, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      tick(); if (i == 2) stall_i = 0;
      @(negedge clk);
      chk("st_hold_data", cpu_data_o, 32'h1234_5678);
      chk("st_hold_cyc", wb_cyc_o, 1'b0);
      chk("st_hold_stall", stallreq_o, 1'b0);
    end
    tick(); cpu_ce_i = 0;
    @(negedge clk);
    chk("st_idle_data", cpu_data_o, 32'h0);
    tick();

    // Flush with ack in 2nd BUSY cycle
    sl_data = 32'hDEAD_BEEF; sl_wait = 1;
    cpu_ce_i = 1; cpu_addr_i = 32'h200;
    tick();
    tick(); flush_i = 1;
    @(negedge clk);
    chk("fl_data", cpu_data_o, 32'h0);
    chk("fl_stall", stallreq_o, 1'b0);
    tick(); flush_i = 0; cpu_ce_i = 0;
    @(negedge clk);
    chk("fl_cyc", wb_cyc_o, 1'b0);
    chk("fl_stb", wb_stb_o, 1'b0);
    chk("fl_err", err_o, 1'b0);
    chk("fl_after_data", cpu_data_o, 32'h0);
    tick();

    // Stray ack while idle
    sl_stray = 1;
    tick(); @(negedge clk);
    chk("stray_cyc", wb_cyc_o, 1'b0);
    chk("stray_data", cpu_data_o, 32'h0);
    sl_stray = 0;
    tick(); tick();

    // Timeout: slave never acks
    sl_never = 1;
    cpu_ce_i = 1; cpu_addr_i = 32'h300;
    for (int i = 1; i <= 4; i++) begin
      tick(); @(negedge clk);
      chk("to_cyc", wb_cyc_o, 1'b1);
      chk("to_stall", stallreq_o, (i < 4));
      chk("to_err_early", err_o, 1'b0);
    end
    tick(); cpu_ce_i = 0;
    @(negedge clk);
    chk("to_err", err_o, 1'b1);
    chk("to_cyc_end", wb_cyc_o, 1'b0);
    tick(); @(negedge clk);
    chk("to_err_once", err_o, 1'b0);

    // Ack in the 4th BUSY cycle beats timeout
    sl_never = 0; sl_wait = 3; sl_data = 32'h0BAD_F00D;
    cpu_ce_i = 1; cpu_addr_i = 32'h304;
    for (int i = 1; i <= 4; i++) begin
      tick(); @(negedge clk);
      chk("ta_cyc", wb_cyc_o, 1'b1);
    end
    chk("ta_data", cpu_data_o, 32'h0BAD_F00D);
    chk("ta_stall", stallreq_o, 1'b0);
    tick(); cpu_ce_i = 0;
    @(negedge clk);
    chk("ta_err", err_o, 1'b0);
    tick(); @(negedge clk);
    chk("ta_err2", err_o, 1'b0);

    // Asynchronous reset mid-BUSY, then a clean fetch
    sl_never = 1;
    cpu_ce_i = 1; cpu_addr_i = 32'h400;
    tick();
    tick(); #2;
    chk("ar_pre_cyc", wb_cyc_o, 1'b1);
    rst = 0; #1;
    chk("ar_cyc", wb_cyc_o, 1'b0);
    chk("ar_stb", wb_stb_o, 1'b0);
    chk("ar_adr", wb_adr_o, 32'h0);
    cpu_ce_i = 0;
    tick(); rst = 1;
    sl_never = 0; sl_wait = 0; sl_data = 32'hCAFE_BABE;
    cpu_ce_i = 1; cpu_addr_i = 32'h8;
    @(negedge clk);
    chk("ar_req_stall", stallreq_o, 1'b1);
    tick(); @(negedge clk);
    chk("ar_data", cpu_data_o, 32'hCAFE_BABE);
    chk("ar_adr2", wb_adr_o, 32'h8);
    tick(); cpu_ce_i = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
